// File: rtl/mips5_pkg.sv
// -----------------------------------------------------------------------------
// mips5_pkg
// Shared definitions for the 5-stage pipeline control slice: controller FSM
// state encoding, register-address constants, counter width and a saturating
// increment helper used by the statistics counters.
// -----------------------------------------------------------------------------
package mips5_pkg;

   localparam int unsigned REG_AW = 5;
   localparam int unsigned CNT_W  = 16;
   localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      ERR     = 2'd2
   } pc_state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
      if (val == {CNT_W{1'b1}}) begin
         sat_inc = val;
      end else begin
         sat_inc = val + 16'd1;
      end
   endfunction

endpackage : mips5_pkg

// File: rtl/pipe_hazard_cmp.sv
// -----------------------------------------------------------------------------
// pipe_hazard_cmp
// Combinational load-use detector. Flags when the instruction in EX is a load
// whose (non-zero) destination is a source register actually read by the
// instruction in ID.
//
// Ports
//   ex_memread   in   EX instruction is a load
//   ex_wraddr    in   EX destination register
//   id_rs/id_rt  in   ID source register fields
//   id_regread1  in   ID reads rs
//   id_regread2  in   ID reads rt
//   lu           out  load-use hazard present
// -----------------------------------------------------------------------------
module pipe_hazard_cmp
   import mips5_pkg::*;
(
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] ex_wraddr,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_regread1,
   input  logic              id_regread2,
   output logic              lu
);

   logic rs_hit_s;
   logic rt_hit_s;

   assign rs_hit_s = id_regread1 & (id_rs == ex_wraddr);
   assign rt_hit_s = id_regread2 & (id_rt == ex_wraddr);

   // r0 is hard-wired zero, so a load targeting it never creates a hazard.
   assign lu = ex_memread & (ex_wraddr != REG_ZERO) & (rs_hit_s | rt_hit_s);

endmodule : pipe_hazard_cmp

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Stall/flush controller for a 5-stage pipeline. Resolves, in priority order,
// watchdog error, data-memory wait, control redirect and load-use hazard into
// the pipeline-register hold/flush controls. A watchdog counts consecutive
// busy memory cycles and latches a sticky error after MEM_TIMEOUT of them;
// only rst clears it.
//
// Parameters
//   MEM_TIMEOUT   max consecutive busy memory cycles tolerated (1..65535)
//
// Configuration
//   PIPE_CTRL_STATS_EN  when defined, stall_cnt / flush_cnt are saturating
//                       event counters; otherwise both are tied to zero.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   id_rs, id_rt             ID source fields
//   id_regread1/2            ID reads rs / rt
//   ex_memread, ex_wraddr    EX load flag and destination
//   ex_redirect              branch taken / jump resolved in EX
//   mem_req, mem_ack         data-memory access active / completes
//   fe_stall, if_id_flush    PC + IF/ID hold, IF/ID NOP load
//   back_stall, id_ex_flush  ID/EX + EX/MEM hold, ID/EX NOP load
//   mem_wb_bubble            MEM/WB captures NOP
//   mem_timeout              sticky watchdog error
//   stall_cnt, flush_cnt     statistics counters
// -----------------------------------------------------------------------------
module pipe_ctrl
   import mips5_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_regread1,
   input  logic              id_regread2,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] ex_wraddr,
   input  logic              ex_redirect,
   input  logic              mem_req,
   input  logic              mem_ack,
   output logic              fe_stall,
   output logic              if_id_flush,
   output logic              back_stall,
   output logic              id_ex_flush,
   output logic              mem_wb_bubble,
   output logic              mem_timeout,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(MEM_TIMEOUT);

   pc_state_t        state_r;
   pc_state_t        state_nxt_s;
   logic [CNT_W-1:0] wcnt_r;
   logic [CNT_W-1:0] wcnt_nxt_s;
   logic             busy_s;
   logic             lu_s;

   assign busy_s = mem_req & ~mem_ack;

   pipe_hazard_cmp u_hazard (
      .ex_memread  (ex_memread),
      .ex_wraddr   (ex_wraddr),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_regread1 (id_regread1),
      .id_regread2 (id_regread2),
      .lu          (lu_s)
   );

   // FSM state and wait-counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= RUN;
         wcnt_r  <= 16'd0;
      end else begin
         state_r <= state_nxt_s;
         wcnt_r  <= wcnt_nxt_s;
      end
   end

   // Next-state logic: wcnt holds the number of busy cycles already completed,
   // so the current busy cycle is number wcnt+1.
   always_comb begin
      state_nxt_s = state_r;
      wcnt_nxt_s  = wcnt_r;
      case (state_r)
         RUN: begin
            if (busy_s) begin
               wcnt_nxt_s = 16'd1;
               if (TIMEOUT_LIM <= 16'd1) begin
                  state_nxt_s = ERR;
               end else begin
                  state_nxt_s = MEMWAIT;
               end
            end else begin
               wcnt_nxt_s = 16'd0;
            end
         end
         MEMWAIT: begin
            if (busy_s) begin
               wcnt_nxt_s = wcnt_r + 16'd1;
               if (wcnt_r >= (TIMEOUT_LIM - 16'd1)) begin
                  state_nxt_s = ERR;
               end else begin
                  state_nxt_s = MEMWAIT;
               end
            end else begin
               state_nxt_s = RUN;
               wcnt_nxt_s  = 16'd0;
            end
         end
         ERR: begin
            state_nxt_s = ERR;
         end
         default: begin
            state_nxt_s = RUN;
            wcnt_nxt_s  = 16'd0;
         end
      endcase
   end

   // Control outputs: error, then memory wait, then redirect, then load-use.
   // Gated by rst so the outputs are quiet for the whole reset pulse.
   always_comb begin
      fe_stall      = 1'b0;
      if_id_flush   = 1'b0;
      back_stall    = 1'b0;
      id_ex_flush   = 1'b0;
      mem_wb_bubble = 1'b0;
      mem_timeout   = 1'b0;
      if (rst) begin
         fe_stall = 1'b0;
      end else if (state_r == ERR) begin
         fe_stall      = 1'b1;
         back_stall    = 1'b1;
         mem_wb_bubble = 1'b1;
         mem_timeout   = 1'b1;
      end else if (busy_s) begin
         fe_stall      = 1'b1;
         back_stall    = 1'b1;
         mem_wb_bubble = 1'b1;
      end else if (ex_redirect) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (lu_s) begin
         fe_stall    = 1'b1;
         id_ex_flush = 1'b1;
      end else begin
         fe_stall = 1'b0;
      end
   end

`ifdef PIPE_CTRL_STATS_EN
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;

   // Saturating counters of stalled cycles and applied redirects.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r <= 16'd0;
         flush_cnt_r <= 16'd0;
      end else begin
         if (fe_stall) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (if_id_flush) begin
            flush_cnt_r <= sat_inc(flush_cnt_r);
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

   assign stall_cnt = stall_cnt_r;
   assign flush_cnt = flush_cnt_r;
`else
   assign stall_cnt = 16'd0;
   assign flush_cnt = 16'd0;
`endif

endmodule : pipe_ctrl
